// File: rtl/hs_rx_pkg.sv
// Shared constants and width helpers for the destination-side packer.
package hs_rx_pkg;

  localparam int HS_WIDTH = 8;
  localparam int HS_PACK  = 4;
  localparam int HS_DEPTH = 4;
  localparam int STATS_W  = 16;

  // Bits needed to index n states; at least one bit so a 2-entry range still has a register.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_rx_fifo.sv
// Synchronous word FIFO with drop-on-full; a push and pop in the same cycle is legal even when full.
module hs_rx_fifo
  import hs_rx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = HS_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              head,
  output logic [bits_for(DEPTH+1)-1:0]  count,
  output logic [bits_for(DEPTH+1)-1:0]  count_nxt,
  output logic                          drop
);

  localparam int AW = bits_for(DEPTH);
  localparam int CW = bits_for(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    full      = (count == CW'(DEPTH));
    rd_en     = pop && (count != '0);
    // A pop in the same cycle frees the slot the push lands in.
    wr_en     = push && (!full || rd_en);
    drop      = push && full && !rd_en;
    count_nxt = count + CW'(wr_en) - CW'(rd_en);
    head      = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Storage carries no reset; the packer masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hs_rx_packer.sv
// Packs PACK items into one word and queues words behind a valid/ready port, back-pressuring the synchronizer.
// Optional item/word counters are enabled with `define HS_RX_PACKER_STATS_EN.
module hs_rx_packer
  import hs_rx_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH,
  parameter int PACK  = HS_PACK,
  parameter int DEPTH = HS_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_busy,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [WIDTH*PACK-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    ovf
`ifdef HS_RX_PACKER_STATS_EN
  ,
  output logic [STATS_W-1:0]      item_cnt,
  output logic [STATS_W-1:0]      word_cnt
`endif
);

  localparam int IW = bits_for(PACK);
  localparam int CW = bits_for(DEPTH+1);
  localparam int WW = WIDTH*PACK;

  logic [IW-1:0] idx_p0;
  logic [WW-1:0] lane_p0;
  logic [WW-1:0] lane_ins;
  logic          complete;
  logic          push;
  logic          pop;
  logic          drop;
  logic [WW-1:0] head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    lane_ins = lane_p0;
    if (in_valid) lane_ins[int'(idx_p0)*WIDTH +: WIDTH] = in_data;
    complete = in_valid && (idx_p0 == IW'(PACK-1));
    // An item arriving with flush joins the word first, so flush at idx 0 still pushes one lane.
    push     = complete || (flush && (in_valid || (idx_p0 != '0)));
    out_valid = (count != '0);
    out_data  = out_valid ? head : '0;
    pop       = out_valid && out_ready;
  end

  // Stage p0: lane assembly, busy and overflow state
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p0  <= '0;
      lane_p0 <= '0;
      in_busy <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (push) begin
        idx_p0  <= '0;
        lane_p0 <= '0;
      end else begin
        if (in_valid) idx_p0 <= idx_p0 + IW'(1);
        lane_p0 <= lane_ins;
      end
      // One slot stays in reserve for an item already in flight when busy is sampled.
      in_busy <= (count_nxt >= CW'(DEPTH-1));
      if (drop) ovf <= 1'b1;
    end
  end

  hs_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (lane_ins),
    .head      (head),
    .count     (count),
    .count_nxt (count_nxt),
    .drop      (drop)
  );

`ifdef HS_RX_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      item_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (in_valid)      item_cnt <= item_cnt + STATS_W'(1);
      if (push && !drop) word_cnt <= word_cnt + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hs_rx_packer.sv
// Bench for hs_rx_packer: directed scenarios plus random traffic against a queue-based model.
module tb_hs_rx_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int DEPTH = 4;
  localparam int WW    = WIDTH*PACK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_busy;
  logic             flush;
  logic             out_valid;
  logic [WW-1:0]    out_data;
  logic             out_ready;
  logic             ovf;
`ifdef HS_RX_PACKER_STATS_EN
  logic [15:0]      item_cnt;
  logic [15:0]      word_cnt;
`endif

  always #5 clk = ~clk;

  hs_rx_packer #(
    .WIDTH (WIDTH),
    .PACK  (PACK),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_busy   (in_busy),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ovf       (ovf)
`ifdef HS_RX_PACKER_STATS_EN
    ,
    .item_cnt  (item_cnt),
    .word_cnt  (word_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0]    q[$];
  logic [WIDTH-1:0] part[$];
  logic             ovf_m  = 1'b0;
  logic             busy_m = 1'b0;
  logic [15:0]      items_m = '0;
  logic [15:0]      words_m = '0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Applies the inputs present at this edge to the abstract model.
  task automatic model_edge();
    logic [WW-1:0] w;
    bit            pend;
    if (rst) begin
      q.delete();
      part.delete();
      ovf_m   = 1'b0;
      items_m = '0;
      words_m = '0;
    end else begin
      bit do_pop;
      do_pop = (q.size() != 0) && out_ready;
      if (in_valid) begin
        part.push_back(in_data);
        items_m++;
      end
      pend = (part.size() == PACK) || (flush && part.size() > 0);
      w = '0;
      if (pend) begin
        for (int i = 0; i < part.size(); i++) w[i*WIDTH +: WIDTH] = part[i];
        part.delete();
      end
      if (do_pop) void'(q.pop_front());
      if (pend) begin
        if (q.size() < DEPTH) begin
          q.push_back(w);
          words_m++;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    busy_m = (q.size() >= DEPTH-1);
  endtask

  task automatic compare();
    chk("out_valid", WW'(out_valid), WW'(q.size() != 0));
    chk("out_data", out_data, (q.size() != 0) ? q[0] : '0);
    chk("in_busy", WW'(in_busy), WW'(busy_m));
    chk("ovf", WW'(ovf), WW'(ovf_m));
`ifdef HS_RX_PACKER_STATS_EN
    chk("item_cnt", WW'(item_cnt), WW'(items_m));
    chk("word_cnt", WW'(word_cnt), WW'(words_m));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] d,
                       input logic f, input logic rdy);
    rst = r; in_valid = v; in_data = d; flush = f; out_ready = rdy;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("reset_out_valid", WW'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_in_busy", WW'(in_busy), '0);
    chk("reset_ovf", WW'(ovf), '0);

    // Four items make one full word
    drive(0, 1, 8'h11, 0, 0);
    drive(0, 1, 8'h22, 0, 0);
    drive(0, 1, 8'h33, 0, 0);
    chk("no_word_before_4th", WW'(out_valid), '0);
    drive(0, 1, 8'h44, 0, 0);
    chk("full_word_valid", WW'(out_valid), 1);
    chk("full_word_data", out_data, 32'h44332211);
    chk("full_word_busy", WW'(in_busy), '0);
    drive(0, 0, 8'h00, 0, 1);

    // Partial word closed by flush, then an empty flush
    drive(0, 1, 8'hAA, 0, 0);
    drive(0, 1, 8'hBB, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk("flush_word_data", out_data, 32'h0000BBAA);
    drive(0, 0, 8'h00, 1, 1);
    chk("empty_flush_no_push", WW'(out_valid), '0);

    // Completing item together with flush gives exactly one word
    drive(0, 1, 8'h01, 0, 0);
    drive(0, 1, 8'h02, 0, 0);
    drive(0, 1, 8'h03, 0, 0);
    drive(0, 1, 8'hCC, 1, 0);
    chk("cc_flush_data", out_data, 32'hCC030201);
    drive(0, 0, 8'h00, 0, 1);
    chk("cc_flush_single_push", WW'(out_valid), '0);

    // Fill to DEPTH-1, then full, then drop
    drive(0, 1, 8'h01, 1, 0);
    drive(0, 1, 8'h02, 1, 0);
    chk("busy_before_3rd", WW'(in_busy), '0);
    drive(0, 1, 8'h03, 1, 0);
    chk("busy_after_3rd", WW'(in_busy), 1);
    drive(0, 1, 8'h04, 1, 0);
    chk("full_no_ovf", WW'(ovf), '0);
    drive(0, 1, 8'h05, 1, 0);
    chk("drop_sets_ovf", WW'(ovf), 1);
    chk("drop_head_kept", out_data, 32'h00000001);

    // Push and pop while full
    drive(0, 1, 8'h06, 1, 1);
    chk("full_pushpop_head", out_data, 32'h00000002);
    chk("full_pushpop_busy", WW'(in_busy), 1);
    chk("full_pushpop_ovf", WW'(ovf), 1);

    // Reset with a partial word and two stored words
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h07, 1, 0);
    drive(0, 1, 8'h08, 1, 0);
    drive(0, 1, 8'h09, 0, 0);
    drive(0, 1, 8'h0A, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    chk("midrst_out_valid", WW'(out_valid), '0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_in_busy", WW'(in_busy), '0);
    chk("midrst_ovf", WW'(ovf), '0);
    drive(0, 1, 8'h55, 0, 0);
    drive(0, 1, 8'h66, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk("post_rst_lane0", out_data, 32'h00006655);

    // Random traffic, including back-to-back items and occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 1)),
            WIDTH'($urandom),
            logic'($urandom_range(0, 6) == 0),
            logic'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
